// File: rtl/backlight_pkg.sv
// Shared types and defaults for the MiniLED backlight PWM path.
package backlight_pkg;

   localparam int PWM_BITS     = 8;
   localparam int DEF_PRESCALE = 10;
   localparam int DEF_MIN_DUTY = 4;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RAMP = 2'd1,
      RUN  = 2'd2
   } bl_state_t;

endpackage

// File: rtl/backlight_pwm_gen_tick.sv
// PWM timebase: prescale counter plus 8-bit tick counter, with first-clock and
// last-clock (boundary) flags for the current period.
module pwm_tick_gen
   import backlight_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic                I_clk,
   input  logic                I_reset,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                period_first,
   output logic                boundary
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [15:0] pre_cnt;
   logic        tick;

   assign tick         = (pre_cnt == PRE_LAST);
   assign boundary     = tick && (pwm_cnt == '1);
   assign period_first = (pre_cnt == '0) && (pwm_cnt == '0);

   always_ff @(posedge I_clk or negedge I_reset) begin
      if (!I_reset) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/backlight_pwm_gen.sv
// Backlight PWM generator: soft-start ramp, min-duty clamp, duty changes only
// at period boundaries so the LED driver never sees a runt pulse.
//
// state | meaning
// OFF   | backlight dark, duty 0, waiting for enable at a boundary
// RAMP  | soft-start, duty steps +1 per period toward target
// RUN   | duty follows clamped brightness once per period
module backlight_pwm_gen
   import backlight_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int MIN_DUTY = DEF_MIN_DUTY
) (
   input  logic                I_clk,
   input  logic                I_reset,
   input  logic                I_enable,
   input  logic [PWM_BITS-1:0] I_bright_data,
   output logic                O_pwm,
   output logic                O_period_start,
   output logic [PWM_BITS-1:0] O_duty,
   output logic                O_busy
);

   localparam logic [PWM_BITS-1:0] MIN_DUTY_V = PWM_BITS'(MIN_DUTY);

   bl_state_t           state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] target;
   logic [PWM_BITS:0]   ramp_inc;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                period_first;
   logic                boundary;

   pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .I_clk        (I_clk),
      .I_reset      (I_reset),
      .pwm_cnt      (pwm_cnt),
      .period_first (period_first),
      .boundary     (boundary)
   );

   assign target   = (I_bright_data < MIN_DUTY_V) ? MIN_DUTY_V : I_bright_data;
   assign ramp_inc = {1'b0, duty_q} + 1'b1;

   always_ff @(posedge I_clk or negedge I_reset) begin
      if (!I_reset) begin
         state_q <= OFF;
         duty_q  <= '0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
      end
   end

   // OFF always holds duty 0, so the first enabled step lands on 1 via ramp_inc.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      if (boundary) begin
         if (!I_enable) begin
            state_d = OFF;
            duty_d  = '0;
         end else begin
            unique case (state_q)
               OFF, RAMP: begin
                  if (ramp_inc >= {1'b0, target}) begin
                     duty_d  = target;
                     state_d = RUN;
                  end else begin
                     duty_d  = ramp_inc[PWM_BITS-1:0];
                     state_d = RAMP;
                  end
               end
               RUN: duty_d = target;
               default: begin
                  state_d = OFF;
                  duty_d  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge I_clk or negedge I_reset) begin
      if (!I_reset) begin
         O_pwm          <= 1'b0;
         O_period_start <= 1'b0;
      end else begin
         O_pwm          <= (pwm_cnt < duty_q);
         O_period_start <= period_first;
      end
   end

   assign O_duty = duty_q;
   assign O_busy = (state_q == RAMP);

endmodule

// File: tb/tb_backlight_pwm_gen.sv
// Directed bench for backlight_pwm_gen with an expected-value queue.
module tb_backlight_pwm_gen;

   localparam int P     = 2;
   localparam int MIN_D = 4;
   localparam int PER   = 256 * P;
   localparam int MAXC  = 4 * PER;

   logic       I_clk = 1'b0;
   logic       I_reset;
   logic       I_enable;
   logic [7:0] I_bright_data;
   logic       O_pwm;
   logic       O_period_start;
   logic [7:0] O_duty;
   logic       O_busy;

   backlight_pwm_gen #(.PRESCALE(P), .MIN_DUTY(MIN_D)) dut (
      .I_clk          (I_clk),
      .I_reset        (I_reset),
      .I_enable       (I_enable),
      .I_bright_data  (I_bright_data),
      .O_pwm          (O_pwm),
      .O_period_start (O_period_start),
      .O_duty         (O_duty),
      .O_busy         (O_busy)
   );

   always #5 I_clk = ~I_clk;

   typedef struct {
      string tag;
      int    value;
   } exp_t;

   exp_t sb_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   fail_cnt  = 0;

   task automatic push(input string tag, input int value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] observed);
      exp_t e;
      total_cnt++;
      if (sb_q.size() == 0) begin
         fail_cnt++;
         $error("FAIL sb_empty: observed %0d expected a queued value", observed);
      end else begin
         e = sb_q.pop_front();
         assert (observed === 32'(e.value)) pass_cnt++;
         else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
         end
      end
   endtask

   task automatic timeout_fail(input string tag);
      total_cnt++;
      fail_cnt++;
      $error("FAIL %s: observed timeout expected event within %0d clocks", tag, MAXC);
   endtask

   // Advance to the next negedge where O_period_start is high.
   task automatic wait_start();
      for (int i = 0; i < MAXC; i++) begin
         @(negedge I_clk);
         if (O_period_start === 1'b1) return;
      end
      timeout_fail("wait_period_start");
   endtask

   // Called at a period-start negedge; counts this period and stops at the next start.
   task automatic measure(input int chg_at, input logic new_en, input logic [7:0] new_bright,
                          output int high, output int len);
      high = 0;
      len  = 0;
      for (int i = 0; i < MAXC; i++) begin
         if (i == chg_at) begin
            I_enable      = new_en;
            I_bright_data = new_bright;
         end
         if (O_pwm === 1'b1) high++;
         len++;
         @(negedge I_clk);
         if (O_period_start === 1'b1) return;
      end
      timeout_fail("measure_period");
   endtask

   initial begin
      int high, len;

      I_reset       = 1'b1;
      I_enable      = 1'b0;
      I_bright_data = 8'd0;
      #2 I_reset    = 1'b0;
      repeat (3) @(negedge I_clk);

      push("rst_pwm", 0);   check(O_pwm);
      push("rst_pstart", 0); check(O_period_start);
      push("rst_duty", 0);  check(O_duty);
      push("rst_busy", 0);  check(O_busy);

      I_reset = 1'b1;
      @(posedge I_clk);
      #1;
      push("first_pstart", 1); check(O_period_start);
      @(negedge I_clk);
      push("off_high", 0);
      push("period_len", PER);
      measure(-1, 1'b0, 8'd0, high, len);
      check(high);
      check(len);

      // soft-start toward 60
      I_enable      = 1'b1;
      I_bright_data = 8'd60;
      for (int k = 1; k <= 60; k++) begin
         push("ramp_duty", k);
         push("ramp_busy", (k < 60) ? 1 : 0);
      end
      for (int k = 1; k <= 60; k++) begin
         wait_start();
         check(O_duty);
         check(O_busy);
      end
      push("ramp_end_high", 60 * P);
      measure(-1, 1'b1, 8'd60, high, len);
      check(high);

      // steady RUN, mid-period change deferred to next period
      I_bright_data = 8'd128;
      push("run_old_high", 60 * P);
      push("run_duty128", 128);
      push("run_mid_high", 128 * P);
      push("run_duty200", 200);
      push("run_200_high", 200 * P);
      measure(-1, 1'b1, 8'd128, high, len);
      check(high);
      check(O_duty);
      measure(PER / 2, 1'b1, 8'd200, high, len);
      check(high);
      check(O_duty);
      measure(-1, 1'b1, 8'd200, high, len);
      check(high);

      // minimum-duty clamp and full-scale duty
      I_bright_data = 8'd0;
      push("clamp_duty", MIN_D);
      push("clamp_high", MIN_D * P);
      wait_start();
      check(O_duty);
      measure(-1, 1'b1, 8'd0, high, len);
      check(high);
      I_bright_data = 8'd255;
      push("full_duty", 255);
      push("full_high", 255 * P);
      push("full_low", P);
      wait_start();
      check(O_duty);
      measure(-1, 1'b1, 8'd255, high, len);
      check(high);
      check(len - high);

      // disable mid-period: current period completes
      I_bright_data = 8'd128;
      push("dis_pre_duty", 128);
      push("dis_last_high", 128 * P);
      push("dis_duty", 0);
      push("dis_busy", 0);
      push("dis_high", 0);
      wait_start();
      check(O_duty);
      measure(10 * P, 1'b0, 8'd128, high, len);
      check(high);
      check(O_duty);
      check(O_busy);
      measure(-1, 1'b0, 8'd128, high, len);
      check(high);

      // re-enable restarts ramp from 1, then reversal at duty 30
      I_enable      = 1'b1;
      I_bright_data = 8'd40;
      push("reen_duty", 1);
      push("reen_busy", 1);
      wait_start();
      check(O_duty);
      check(O_busy);
      repeat (29) wait_start();
      push("rev_at_duty", 30);
      check(O_duty);
      I_bright_data = 8'd12;
      push("rev_duty", 12);
      push("rev_busy", 0);
      push("rev_high", 12 * P);
      push("rev_hold_duty", 12);
      push("rev_hold_busy", 0);
      wait_start();
      check(O_duty);
      check(O_busy);
      measure(-1, 1'b1, 8'd12, high, len);
      check(high);
      check(O_duty);
      check(O_busy);

      // asynchronous reset while O_pwm is high
      push("mid_pwm_high", 1);
      check(O_pwm);
      I_reset = 1'b0;
      #1;
      push("mid_rst_pwm", 0);    check(O_pwm);
      push("mid_rst_pstart", 0); check(O_period_start);
      push("mid_rst_duty", 0);   check(O_duty);
      push("mid_rst_busy", 0);   check(O_busy);
      @(negedge I_clk);
      I_reset = 1'b1;
      @(posedge I_clk);
      #1;
      push("rel_pstart", 1); check(O_period_start);
      push("rel_duty", 0);   check(O_duty);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/backlight_pwm_gen.md
Name: backlight_pwm_gen

Overview:
Downstream consumer of the ambient-light brightness path.
- Takes the smoothed 8-bit backlight level and drives the MiniLED backlight enable line as a fixed-frequency, glitch-free PWM.
- Duty updates are applied only at PWM period boundaries.
- Soft-start ramp on enable; minimum-duty clamp keeps the backlight lit.

Parameters:
- PRESCALE, 10: I_clk cycles per PWM tick. Period = 256*PRESCALE clocks (2560 clocks, 19.53 kHz at 50 MHz). Legal range 1..65535.
- MIN_DUTY, 4: lower clamp applied to the requested duty while enabled.

Ports:
- I_clk  input  1  system clock, 50 MHz.
- I_reset  input  1  asynchronous, active-low reset.
- I_enable  input  1  backlight enable, level. Sampled only at period boundaries.
- I_bright_data  input  8  requested brightness (level signal from the ALS stage). Sampled only at period boundaries.
- O_pwm  output  1  PWM drive to the LED driver, registered.
- O_period_start  output  1  one-clock pulse on the first clock of every PWM period, registered.
- O_duty  output  8  duty currently being applied.
- O_busy  output  1  high while the soft-start ramp is in progress.

Behaviour:
Reset (async, I_reset low):
- O_pwm=0, O_period_start=0, O_duty=0, O_busy=0.
- State OFF; prescale counter and tick counter cleared.
- Takes effect immediately, including mid-period.
- After release, the first period starts on the first clock edge with I_reset high.

Counters:
- Prescale counter runs 0..PRESCALE-1.
- Tick counter pwm_cnt (8 bit) increments when the prescale counter wraps; pwm_cnt wraps 255->0.
- Boundary = last clock of the period (pwm_cnt=255 and prescale counter = PRESCALE-1).

Per-period output:
- O_period_start=1 on the first clock of each period.
- O_pwm=1 while pwm_cnt < O_duty, registered so it is aligned with O_period_start.
- High time = O_duty*PRESCALE clocks; duty 255 gives 255/256; duty 0 gives constant low.

Target:
- target = max(I_bright_data, MIN_DUTY), captured only at the boundary.
- Changes to I_bright_data mid-period are ignored until the next boundary.

FSM (evaluated only at the boundary; all other clocks hold state and O_duty):
- OFF: O_duty=0, O_busy=0. If I_enable=1, go to RAMP and set O_busy=1.
- RAMP: O_duty <= min(O_duty+1, target).
  - If the new O_duty equals target, go to RUN and set O_busy=0.
  - If target falls below O_duty during the ramp, O_duty snaps to target, then go to RUN.
- RUN: O_duty <= target every boundary; no slew here, the upstream stage already smooths.
- From RAMP or RUN, I_enable=0 at a boundary: go to OFF, O_duty=0, O_busy=0. The current period always completes (no runt pulse).

Timing:
- Latency from a boundary sample to the new duty on O_pwm is 1 clock (the following period).
- An I_enable pulse shorter than a period that misses a boundary is ignored.

Widths:
- The max() compare is 8-bit unsigned.
- The ramp increment is computed in 9 bits, so 255+1 never wraps.

Decomposition:
Shared package backlight_pkg holds:
- state typedef {OFF, RAMP, RUN}
- PWM_BITS=8
- default PRESCALE and MIN_DUTY constants

Sub-module pwm_tick_gen (prescale counter, tick pulse and period-boundary pulse) is natural and reusable for per-zone dimming later. The FSM and compare stay in backlight_pwm_gen.

Test Plan:
1. Reset: assert I_reset low mid-period with O_pwm=1 -> O_pwm, O_duty, O_busy and O_period_start all 0 within the same clock; after release, O_period_start is first seen 1 clock after the release edge.
2. Soft-start: I_enable=1, I_bright_data=100 -> O_busy=1; O_duty increments by 1 per 2560-clock period and reaches 100 at the 100th boundary; O_busy drops the same clock; O_pwm is high for 1000 of 2560 clocks thereafter.
3. Steady RUN: input changes 128->200 mid-period -> current period still high 1280 clocks; next period high 2000 clocks; no intermediate value.
4. Min clamp: RUN with I_bright_data=0 -> O_duty=4, O_pwm high 40 clocks per period; input 255 -> high 2550 clocks, low 10.
5. Ramp reversal: during ramp at O_duty=50, input drops to 20 -> next boundary O_duty=20, O_busy=0, state RUN.
6. Disable mid-period: I_enable low at pwm_cnt=10 with duty 128 -> period completes with 1280 high clocks; from the next period O_pwm stays 0 and O_duty=0; re-enable restarts the ramp from 1.
